// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - shared codes for the RV32I execute stage
package execute_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/execute_stage_alu.sv
// rtl/execute_stage_alu.sv - combinational RV32I ALU
module execute_stage_alu
  import execute_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [3:0]      ALUControl,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero
);

  logic [4:0] w_shamt;

  assign w_shamt = SrcB[4:0];

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      ALU_ADD:  ALUResult = SrcA + SrcB;
      ALU_SUB:  ALUResult = SrcA - SrcB;
      ALU_AND:  ALUResult = SrcA & SrcB;
      ALU_OR:   ALUResult = SrcA | SrcB;
      ALU_XOR:  ALUResult = SrcA ^ SrcB;
      ALU_SLT:  ALUResult[0] = $signed(SrcA) < $signed(SrcB);
      ALU_SLTU: ALUResult[0] = SrcA < SrcB;
      ALU_SLL:  ALUResult = SrcA << w_shamt;
      ALU_SRL:  ALUResult = SrcA >> w_shamt;
      ALU_SRA:  ALUResult = $signed(SrcA) >>> w_shamt;
      default:  ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32I execute stage: forwarding, ALU, branch resolve, EX/MEM register
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic            RegWriteE,
  input  logic            ALUSrcE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            JalSrcE,
  input  logic            USrcE,
  input  logic            UOControlE,
  input  logic [1:0]      ResultSrcE,
  input  logic [3:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [4:0]      RdE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            ZeroE,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RdM
);

  logic [XLEN-1:0] w_src_af;
  logic [XLEN-1:0] w_src_bf;
  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_zero;

  logic            r_reg_write;
  logic            r_mem_write;
  logic [1:0]      r_result_src;
  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_write_data;
  logic [XLEN-1:0] r_pc_plus4;
  logic [4:0]      r_rd;

  // Select 11 falls into the default and behaves like the register value.
  always_comb begin
    w_src_af = RD1E;
    case (ForwardAE)
      FWD_WB:  w_src_af = ResultW;
      FWD_MEM: w_src_af = r_alu_result;
      default: w_src_af = RD1E;
    endcase
  end

  always_comb begin
    w_src_bf = RD2E;
    case (ForwardBE)
      FWD_WB:  w_src_bf = ResultW;
      FWD_MEM: w_src_bf = r_alu_result;
      default: w_src_bf = RD2E;
    endcase
  end

  assign w_src_a = USrcE ? (UOControlE ? PCE : '0) : w_src_af;
  assign w_src_b = ALUSrcE ? ImmExtE : w_src_bf;

  execute_stage_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .SrcA      (w_src_a),
    .SrcB      (w_src_b),
    .ALUControl(ALUControlE),
    .ALUResult (w_alu_result),
    .Zero      (w_zero)
  );

  assign ZeroE     = w_zero;
  assign PCSrcE    = (BranchE & w_zero) | JumpE;
  assign PCTargetE = JalSrcE ? {w_alu_result[XLEN-1:1], 1'b0} : (PCE + ImmExtE);

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 2'b00;
      r_alu_result <= '0;
      r_write_data <= '0;
      r_pc_plus4   <= '0;
      r_rd         <= '0;
    end else begin
      r_reg_write  <= RegWriteE;
      r_mem_write  <= MemWriteE;
      r_result_src <= ResultSrcE;
      r_alu_result <= w_alu_result;
      r_write_data <= w_src_bf;
      r_pc_plus4   <= PCPlus4E;
      r_rd         <= RdE;
    end
  end

  assign RegWriteM  = r_reg_write;
  assign MemWriteM  = r_mem_write;
  assign ResultSrcM = r_result_src;
  assign ALUResultM = r_alu_result;
  assign WriteDataM = r_write_data;
  assign PCPlus4M   = r_pc_plus4;
  assign RdM        = r_rd;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage
module tb_execute_stage;

  logic        CLK;
  logic        CLR;
  logic        RegWriteE, ALUSrcE, MemWriteE, JumpE, BranchE, JalSrcE, USrcE, UOControlE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        ZeroE, PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // reference EX/MEM contents
  logic        m_rw, m_mw;
  logic [1:0]  m_rs;
  logic [31:0] m_alu, m_wd, m_pc4;
  logic [4:0]  m_rd;

  execute_stage #(.XLEN(32)) dut (
    .CLK(CLK), .CLR(CLR),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .JalSrcE(JalSrcE), .USrcE(USrcE), .UOControlE(UOControlE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .ZeroE(ZeroE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    s = b[4:0];
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << s;
      4'd8: return a >> s;
      4'd9: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v);
    if (sel == 2'b01) return ResultW;
    if (sel == 2'b10) return m_alu;
    return reg_v;
  endfunction

  function automatic logic [31:0] ref_result();
    logic [31:0] a, b;
    a = USrcE ? (UOControlE ? PCE : 32'd0) : pick(ForwardAE, RD1E);
    b = ALUSrcE ? ImmExtE : pick(ForwardBE, RD2E);
    return ref_alu(ALUControlE, a, b);
  endfunction

  always @(posedge CLK) begin
    logic [31:0] res, wd;
    res = ref_result();
    wd  = pick(ForwardBE, RD2E);
    if (CLR) begin
      m_rw = 0; m_mw = 0; m_rs = 0; m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;
    end else begin
      m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE;
      m_alu = res; m_wd = wd; m_pc4 = PCPlus4E; m_rd = RdE;
    end
  end

  always @(negedge CLK) begin
    logic [31:0] res, tgt;
    if (chk_en) begin
      res = ref_result();
      tgt = JalSrcE ? (res & 32'hFFFF_FFFE) : (PCE + ImmExtE);
      chk("ZeroE", 32'(ZeroE), 32'(res == 0));
      chk("PCSrcE", 32'(PCSrcE), 32'((BranchE && res == 0) || JumpE));
      chk("PCTargetE", PCTargetE, tgt);
      chk("RegWriteM", 32'(RegWriteM), 32'(m_rw));
      chk("MemWriteM", 32'(MemWriteM), 32'(m_mw));
      chk("ResultSrcM", 32'(ResultSrcM), 32'(m_rs));
      chk("ALUResultM", ALUResultM, m_alu);
      chk("WriteDataM", WriteDataM, m_wd);
      chk("PCPlus4M", PCPlus4M, m_pc4);
      chk("RdM", 32'(RdM), 32'(m_rd));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0;
    JalSrcE = 0; USrcE = 0; UOControlE = 0; ResultSrcE = 0; ALUControlE = 0;
    RD1E = 0; RD2E = 0; PCE = 0; PCPlus4E = 0; ImmExtE = 0; RdE = 0;
    ForwardAE = 0; ForwardBE = 0; ResultW = 0;
  endtask

  task automatic randomize_inputs();
    {RegWriteE, ALUSrcE, MemWriteE, JumpE, BranchE, JalSrcE, USrcE, UOControlE} = 8'($urandom);
    ResultSrcE = 2'($urandom); ALUControlE = 4'($urandom);
    RD1E = $urandom; RD2E = $urandom; PCE = $urandom; PCPlus4E = $urandom;
    ImmExtE = $urandom; RdE = 5'($urandom);
    ForwardAE = 2'($urandom); ForwardBE = 2'($urandom); ResultW = $urandom;
    if ($urandom_range(0, 3) == 0) RD2E = RD1E;
  endtask

  initial begin
    idle();
    CLR = 1;
    // reset with noise on the inputs; redirect must still follow JumpE
    for (int i = 0; i < 2; i++) begin
      randomize_inputs();
      BranchE = 0;
      #1 chk("rst_pcsrc_follows_jump", 32'(PCSrcE), 32'(JumpE));
      step();
      chk_en = 1;
    end
    chk("rst_RegWriteM", 32'(RegWriteM), 32'd0);
    chk("rst_MemWriteM", 32'(MemWriteM), 32'd0);
    chk("rst_ResultSrcM", 32'(ResultSrcM), 32'd0);
    chk("rst_ALUResultM", ALUResultM, 32'd0);
    chk("rst_WriteDataM", WriteDataM, 32'd0);
    chk("rst_PCPlus4M", PCPlus4M, 32'd0);
    chk("rst_RdM", 32'(RdM), 32'd0);

    CLR = 0;
    idle();
    RD1E = 5; RD2E = 3; RegWriteE = 1; RdE = 7;
    step();
    chk("add_5_3", ALUResultM, 32'd8);
    chk("add_rd", 32'(RdM), 32'd7);
    chk("add_regwrite", 32'(RegWriteM), 32'd1);

    RD2E = 5; ALUControlE = 4'b0001; BranchE = 1;
    #1;
    chk("sub_zero", 32'(ZeroE), 32'd1);
    chk("beq_taken", 32'(PCSrcE), 32'd1);
    step();
    chk("sub_result", ALUResultM, 32'd0);

    idle();
    RD1E = 32'h10;
    step();
    ForwardAE = 2'b10; RD1E = 32'h999; ALUSrcE = 1; ImmExtE = 4;
    step();
    chk("fwd_mem_a", ALUResultM, 32'h14);

    idle();
    ForwardBE = 2'b01; ResultW = 32'hAB; RD2E = 32'h55; MemWriteE = 1; ALUSrcE = 1;
    step();
    chk("fwd_wb_store", WriteDataM, 32'hAB);
    chk("store_memwrite", 32'(MemWriteM), 32'd1);

    idle();
    JumpE = 1; JalSrcE = 1; RD1E = 32'h1001; ImmExtE = 2; ALUSrcE = 1;
    ResultSrcE = 2'b10; PCE = 32'h2000; PCPlus4E = 32'h2004; RegWriteE = 1;
    #1;
    chk("jalr_target", PCTargetE, 32'h1002);
    chk("jalr_pcsrc", 32'(PCSrcE), 32'd1);
    step();
    chk("jalr_pc4", PCPlus4M, 32'h2004);
    chk("jalr_ressrc", 32'(ResultSrcM), 32'd2);

    JalSrcE = 0; ImmExtE = 32'h10;
    #1 chk("jal_target", PCTargetE, 32'h2010);

    idle();
    RD1E = 32'h8000_0000; RD2E = 32'h21; ALUControlE = 4'b1001;
    step();
    chk("sra", ALUResultM, 32'hC000_0000);
    RD1E = 32'hFFFF_FFFF; RD2E = 1; ALUControlE = 4'b0101;
    step();
    chk("slt", ALUResultM, 32'd1);
    ALUControlE = 4'b0110;
    step();
    chk("sltu", ALUResultM, 32'd0);
    ALUControlE = 4'b1111;
    step();
    chk("op_1111", ALUResultM, 32'd0);

    idle();
    USrcE = 1; UOControlE = 1; PCE = 32'h100; ImmExtE = 32'h2000; ALUSrcE = 1; RD1E = 32'h77;
    step();
    chk("auipc", ALUResultM, 32'h2100);
    UOControlE = 0;
    step();
    chk("lui", ALUResultM, 32'h2000);

    idle();
    ForwardAE = 2'b10; ForwardBE = 2'b10; RD1E = 1; RD2E = 2;
    step();
    chk("both_fwd_mem", ALUResultM, 32'h4000);
    ForwardAE = 2'b11; ForwardBE = 2'b00; RD1E = 32'h30; RD2E = 32'h5;
    step();
    chk("fwd_11_as_reg", ALUResultM, 32'h35);

    idle();
    CLR = 1; RD1E = 1; RD2E = 2; RegWriteE = 1; RdE = 3;
    step();
    chk("midrst_lost", ALUResultM, 32'd0);
    chk("midrst_rw", 32'(RegWriteM), 32'd0);
    CLR = 0; RD1E = 3; RD2E = 4;
    step();
    chk("after_rst", ALUResultM, 32'd7);

    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      CLR = ($urandom_range(0, 19) == 0);
      step();
    end
    CLR = 0;
    idle();
    step();
    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
